// File: rtl/mem_bus_arbiter_if.sv
// Bundle of Icache, Dcache and memory-port signals around mem_bus_arbiter.
// The ic_abort line exists only when ICACHE_ABORT_EN is defined.
interface mem_bus_arbiter_if #(
    parameter int BEAT_W = 2
);
    logic              ic_req;
    logic [31:0]       ic_addr;
    logic              ic_gnt;
    logic              ic_rvalid;
    logic [31:0]       ic_rdata;
    logic [BEAT_W-1:0] ic_beat;
    logic              ic_done;
`ifdef ICACHE_ABORT_EN
    logic              ic_abort;
`endif
    logic              dc_req;
    logic              dc_we;
    logic [31:0]       dc_addr;
    logic [31:0]       dc_wdata;
    logic              dc_wnext;
    logic              dc_gnt;
    logic              dc_rvalid;
    logic [31:0]       dc_rdata;
    logic              dc_done;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    // master: the arbiter itself; slave: caches plus memory around it
    modport master (
`ifdef ICACHE_ABORT_EN
        input  ic_abort,
`endif
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output ic_gnt, ic_rvalid, ic_rdata, ic_beat, ic_done,
        output dc_wnext, dc_gnt, dc_rvalid, dc_rdata, dc_done,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
`ifdef ICACHE_ABORT_EN
        output ic_abort,
`endif
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  ic_gnt, ic_rvalid, ic_rdata, ic_beat, ic_done,
        input  dc_wnext, dc_gnt, dc_rvalid, dc_rdata, dc_done,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the memory port for Icache/Dcache line bursts; read data returns one cycle after mem_rvalid.
// Beats wait on mem_ready; define ICACHE_ABORT_EN to allow Icache burst abort with DRAIN.
module mem_bus_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int BEAT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master bus
);
    localparam int               CNT_W    = BEAT_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BURST_LEN);
    localparam logic [31:0]      LINE_OFS = 32'(BURST_LEN * 4 - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IC_RD = 3'd1,
        DC_RD = 3'd2,
        DC_WR = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      base;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic             last_dc;
    logic             in_burst, issuing, hs, rd_ret, last_ret;
    logic             pick_ic, pick_dc, abort;

    always_comb begin
        state_nxt = state;
        pick_ic   = 1'b0;
        pick_dc   = 1'b0;
        abort     = 1'b0;
        in_burst  = (state == IC_RD) || (state == DC_RD) || (state == DC_WR);
        issuing   = in_burst && (issue_cnt < CNT_FULL);
        hs        = issuing && bus.mem_ready;
        rd_ret    = bus.mem_rvalid && ((state == IC_RD) || (state == DC_RD) || (state == DRAIN));
        last_ret  = rd_ret && (ret_cnt == CNT_LAST);
        case (state)
            IDLE: begin
                // last_dc resets high so the Icache wins the boot-time tie
                pick_ic = bus.ic_req && (!bus.dc_req || last_dc);
                pick_dc = bus.dc_req && !pick_ic;
                if (pick_ic) begin
                    state_nxt = IC_RD;
                end else if (pick_dc) begin
                    state_nxt = bus.dc_we ? DC_WR : DC_RD;
                end
            end
            IC_RD: begin
                if (last_ret) begin
                    state_nxt = IDLE;
                end
`ifdef ICACHE_ABORT_EN
                else if (bus.ic_abort) begin
                    abort     = 1'b1;
                    state_nxt = ((issue_cnt + CNT_W'(hs)) == (ret_cnt + CNT_W'(rd_ret))) ? IDLE : DRAIN;
                end
`endif
            end
            DC_RD: begin
                if (last_ret) begin
                    state_nxt = IDLE;
                end
            end
            DC_WR: begin
                if (hs && (issue_cnt == CNT_LAST)) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if ((ret_cnt + CNT_W'(rd_ret)) == issue_cnt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mem_req   = issuing;
    assign bus.mem_we    = (state == DC_WR);
    assign bus.mem_addr  = base + 32'({issue_cnt, 2'b00});
    assign bus.mem_wdata = bus.dc_wdata;
    assign bus.dc_wnext  = hs && (state == DC_WR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base          <= '0;
            issue_cnt     <= '0;
            ret_cnt       <= '0;
            last_dc       <= 1'b1;
            bus.ic_gnt    <= 1'b0;
            bus.ic_rvalid <= 1'b0;
            bus.ic_rdata  <= '0;
            bus.ic_beat   <= '0;
            bus.ic_done   <= 1'b0;
            bus.dc_gnt    <= 1'b0;
            bus.dc_rvalid <= 1'b0;
            bus.dc_rdata  <= '0;
            bus.dc_done   <= 1'b0;
        end else begin
            bus.ic_gnt    <= 1'b0;
            bus.dc_gnt    <= 1'b0;
            bus.ic_rvalid <= 1'b0;
            bus.dc_rvalid <= 1'b0;
            bus.ic_done   <= 1'b0;
            bus.dc_done   <= 1'b0;
            if (pick_ic || pick_dc) begin
                base       <= (pick_ic ? bus.ic_addr : bus.dc_addr) & ~LINE_OFS;
                issue_cnt  <= '0;
                ret_cnt    <= '0;
                last_dc    <= pick_dc;
                bus.ic_gnt <= pick_ic;
                bus.dc_gnt <= pick_dc;
            end else begin
                if (hs) begin
                    issue_cnt <= issue_cnt + 1'b1;
                end
                if (rd_ret) begin
                    ret_cnt <= ret_cnt + 1'b1;
                end
            end
            // an aborting cycle swallows its return unless it is the final one
            if (rd_ret && (state == IC_RD) && !abort) begin
                bus.ic_rvalid <= 1'b1;
                bus.ic_rdata  <= bus.mem_rdata;
                bus.ic_beat   <= ret_cnt[BEAT_W-1:0];
                bus.ic_done   <= last_ret;
            end
            if (rd_ret && (state == DC_RD)) begin
                bus.dc_rvalid <= 1'b1;
                bus.dc_rdata  <= bus.mem_rdata;
                bus.dc_done   <= last_ret;
            end
            if (bus.dc_wnext && (issue_cnt == CNT_LAST)) begin
                bus.dc_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; the abort scenario is built only with ICACHE_ABORT_EN.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    localparam int          BURST_LEN = 4;
    localparam int          BEAT_W    = 2;
    localparam logic [31:0] RMASK     = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;
    logic        auto_mem, man_rv;
    logic [31:0] man_rdata;
    logic [1:0]  pv;
    logic [31:0] pa0, pa1;

    mem_bus_arbiter_if #(.BEAT_W(BEAT_W)) bus ();

    mem_bus_arbiter #(.BURST_LEN(BURST_LEN), .BEAT_W(BEAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // memory model: read data returns two cycles after each accepted read beat
    always @(posedge clk) begin
        if (rst) begin
            pv <= 2'b00;
        end else begin
            pv <= {pv[0], bus.mem_req & bus.mem_ready & ~bus.mem_we};
        end
        pa1 <= pa0;
        pa0 <= bus.mem_addr;
    end
    assign bus.mem_rvalid = auto_mem ? pv[1] : man_rv;
    assign bus.mem_rdata  = auto_mem ? (pa1 ^ RMASK) : man_rdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.ic_req    = 1'b0;
        bus.ic_addr   = '0;
        bus.dc_req    = 1'b0;
        bus.dc_we     = 1'b0;
        bus.dc_addr   = '0;
        bus.dc_wdata  = '0;
        bus.mem_ready = 1'b0;
`ifdef ICACHE_ABORT_EN
        bus.ic_abort  = 1'b0;
`endif
        auto_mem      = 1'b1;
        man_rv        = 1'b0;
        man_rdata     = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] ctl;
        do_reset();
        #1;
        ctl = {bus.ic_gnt, bus.ic_rvalid, bus.ic_done, bus.dc_gnt, bus.dc_rvalid,
               bus.dc_done, bus.dc_wnext, bus.mem_req, bus.mem_we};
        checks++;
        if (ctl !== 9'd0) begin errors++; $display("FAIL reset_ctl: got %b expected 0", ctl); end
        checks++;
        if ({bus.ic_rdata, bus.dc_rdata, bus.mem_addr} !== 96'd0 || bus.ic_beat !== 2'd0) begin
            errors++; $display("FAIL reset_data: got %h/%h/%h expected 0", bus.ic_rdata, bus.dc_rdata, bus.mem_addr);
        end
        checks++;
        if (dut.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dut.state); end
    endtask

    task automatic test_ic_burst();
        int gnts = 0, beats = 0, dones = 0, other = 0;
        bit fin = 0;
        logic [31:0] acc[$];
        do_reset();
        bus.ic_addr = 32'h1008; bus.ic_req = 1'b1; bus.mem_ready = 1'b1;
        for (int c = 0; c < 30 && !fin; c++) begin
            step();
            if (bus.ic_gnt) bus.ic_req = 1'b0;
            #1;
            if (bus.ic_gnt) gnts++;
            if (bus.dc_gnt || bus.dc_rvalid || bus.dc_done) other++;
            if (bus.mem_req && bus.mem_ready) acc.push_back(bus.mem_addr);
            if (bus.ic_rvalid) begin
                checks++;
                if (bus.ic_beat !== BEAT_W'(beats) || bus.ic_rdata !== (32'(32'h1000 + 4 * beats) ^ RMASK)) begin
                    errors++; $display("FAIL ic_beat%0d: got beat %0d data %h", beats, bus.ic_beat, bus.ic_rdata);
                end
                beats++;
            end
            if (bus.ic_done) begin
                dones++; fin = 1;
                checks++;
                if (!bus.ic_rvalid || bus.ic_beat !== 2'd3) begin
                    errors++; $display("FAIL ic_done_beat: got rvalid %b beat %0d expected 1/3", bus.ic_rvalid, bus.ic_beat);
                end
            end
        end
        checks++;
        if (gnts != 1) begin errors++; $display("FAIL ic_gnt_count: got %0d expected 1", gnts); end
        checks++;
        if (acc.size() != 4) begin errors++; $display("FAIL ic_issue_count: got %0d expected 4", acc.size()); end
        for (int i = 0; i < acc.size() && i < 4; i++) begin
            checks++;
            if (acc[i] !== 32'(32'h1000 + 4 * i)) begin
                errors++; $display("FAIL ic_addr%0d: got %h expected %h", i, acc[i], 32'h1000 + 4 * i);
            end
        end
        checks++;
        if (beats != 4 || dones != 1 || other != 0) begin
            errors++; $display("FAIL ic_totals: got beats %0d dones %0d dc %0d expected 4 1 0", beats, dones, other);
        end
        step(); #1;
        checks++;
        if (dut.state !== 3'd0 || bus.ic_rvalid !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL ic_idle_after: got state %0d rvalid %b req %b expected 0", dut.state, bus.ic_rvalid, bus.mem_req);
        end
    endtask

    task automatic test_tie();
        int ig = -1, idn = -1, dg = -1, ddn = -1, owner = 0, bad = 0, ib = 0, db = 0;
        do_reset();
        bus.ic_addr = 32'h1000; bus.dc_addr = 32'h3000; bus.dc_we = 1'b0;
        bus.ic_req = 1'b1; bus.dc_req = 1'b1; bus.mem_ready = 1'b1;
        for (int c = 0; c < 60 && ddn < 0; c++) begin
            step();
            if (bus.ic_gnt) begin ig = c; owner = 1; bus.ic_req = 1'b0; end
            if (bus.dc_gnt) begin dg = c; owner = 2; bus.dc_req = 1'b0; end
            #1;
            if (bus.ic_rvalid) begin if (owner != 1) bad++; ib++; end
            if (bus.dc_rvalid) begin
                if (owner != 2) bad++;
                checks++;
                if (bus.dc_rdata !== (32'(32'h3000 + 4 * db) ^ RMASK)) begin
                    errors++; $display("FAIL tie_dc_data%0d: got %h", db, bus.dc_rdata);
                end
                db++;
            end
            if (bus.ic_done) begin idn = c; if (owner != 1) bad++; end
            if (bus.dc_done) begin ddn = c; if (owner != 2) bad++; end
        end
        checks++;
        if (ig < 0 || dg <= ig) begin errors++; $display("FAIL tie_order: got ic_gnt@%0d dc_gnt@%0d expected ic first", ig, dg); end
        checks++;
        if (dg != idn + 1) begin errors++; $display("FAIL tie_dc_gnt_time: got %0d expected %0d", dg, idn + 1); end
        checks++;
        if (bad != 0 || ib != 4 || db != 4) begin
            errors++; $display("FAIL tie_ownership: got bad %0d ic %0d dc %0d expected 0 4 4", bad, ib, db);
        end
        bus.ic_req = 1'b1; bus.dc_req = 1'b1;
        step(); #1;
        checks++;
        if ({bus.ic_gnt, bus.dc_gnt} !== 2'b10) begin
            errors++; $display("FAIL tie_second: got ic/dc gnt %b%b expected 10", bus.ic_gnt, bus.dc_gnt);
        end
    endtask

    task automatic test_writeback();
        int wn = 0, lwc = -1, dnc = -1, stray = 0, phase = 0;
        bit started = 0, adv = 0;
        do_reset();
        bus.dc_addr = 32'h2000; bus.dc_we = 1'b1; bus.dc_req = 1'b1;
        bus.dc_wdata = 32'hD000_0000; bus.mem_ready = 1'b1;
        for (int c = 0; c < 40 && dnc < 0; c++) begin
            step();
            if (adv) begin bus.dc_wdata = 32'(32'hD000_0000 + wn); adv = 0; end
            if (bus.dc_gnt) begin started = 1; bus.dc_req = 1'b0; end
            if (started) begin bus.mem_ready = (phase % 2 == 0); phase++; end
            #1;
            if (bus.mem_req) begin
                checks++;
                if (bus.mem_wdata !== bus.dc_wdata) begin
                    errors++; $display("FAIL wb_wdata_track: got %h expected %h", bus.mem_wdata, bus.dc_wdata);
                end
            end
            if (bus.dc_wnext) begin
                checks++;
                if ({bus.mem_ready, bus.mem_req, bus.mem_we} !== 3'b111 || bus.mem_addr !== 32'(32'h2000 + 4 * wn)
                    || bus.mem_wdata !== 32'(32'hD000_0000 + wn)) begin
                    errors++; $display("FAIL wb_beat%0d: got addr %h data %h expected %h", wn, bus.mem_addr, bus.mem_wdata, 32'h2000 + 4 * wn);
                end
                wn++; lwc = c; adv = 1;
            end else if (bus.mem_req && bus.mem_ready) begin
                stray++;
            end
            if (bus.dc_rvalid || bus.ic_rvalid) stray++;
            if (bus.dc_done) dnc = c;
        end
        checks++;
        if (wn != 4 || stray != 0) begin errors++; $display("FAIL wb_wnext_count: got %0d stray %0d expected 4 0", wn, stray); end
        checks++;
        if (dnc != lwc + 1) begin errors++; $display("FAIL wb_done_time: got %0d expected %0d", dnc, lwc + 1); end
        step(); #1;
        checks++;
        if (bus.dc_done !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL wb_done_pulse: got done %b req %b expected 0 0", bus.dc_done, bus.mem_req);
        end
    endtask

    task automatic test_stall();
        int acc = 0, stall = -1, rv = 0, dn = -1;
        do_reset();
        bus.ic_addr = 32'h4000; bus.ic_req = 1'b1; bus.mem_ready = 1'b1;
        for (int c = 0; c < 50 && dn < 0; c++) begin
            step();
            if (bus.ic_gnt) bus.ic_req = 1'b0;
            if (acc == 2 && stall < 0) stall = 5;
            bus.mem_ready = (stall <= 0);
            #1;
            if (stall > 0) begin
                checks++;
                if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4008) begin
                    errors++; $display("FAIL stall_hold%0d: got req %b addr %h expected 1 00004008", stall, bus.mem_req, bus.mem_addr);
                end
                stall--;
            end
            if (bus.mem_req && bus.mem_ready) begin
                checks++;
                if (bus.mem_addr !== 32'(32'h4000 + 4 * acc)) begin
                    errors++; $display("FAIL stall_addr%0d: got %h", acc, bus.mem_addr);
                end
                acc++;
            end
            if (bus.ic_rvalid) rv++;
            if (bus.ic_done) dn = c;
        end
        checks++;
        if (acc != 4 || rv != 4 || dn < 0) begin
            errors++; $display("FAIL stall_complete: got acc %0d rvalid %0d done@%0d expected 4 4 done", acc, rv, dn);
        end
    endtask

    task automatic test_rst_mid();
        int db = 0;
        logic [8:0] ctl;
        do_reset();
        auto_mem = 1'b0;
        bus.dc_addr = 32'h5000; bus.dc_we = 1'b0; bus.dc_req = 1'b1; bus.mem_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.dc_gnt) bus.dc_req = 1'b0;
            man_rv    = (c == 2 || c == 3 || c == 6);
            man_rdata = 32'(32'h5500_0000 + c);
            rst       = (c == 5);
            #1;
            if (bus.dc_rvalid) db++;
            if (c == 4) begin
                checks++;
                if (db != 2 || bus.dc_rdata !== 32'h5500_0003) begin
                    errors++; $display("FAIL rst_pre_beats: got %0d data %h expected 2 55000003", db, bus.dc_rdata);
                end
            end
            if (c == 6) begin
                ctl = {bus.ic_gnt, bus.ic_rvalid, bus.ic_done, bus.dc_gnt, bus.dc_rvalid,
                       bus.dc_done, bus.dc_wnext, bus.mem_req, bus.mem_we};
                checks++;
                if (ctl !== 9'd0 || bus.dc_rdata !== 32'd0 || bus.mem_addr !== 32'd0 || dut.state !== 3'd0) begin
                    errors++; $display("FAIL rst_mid_clear: got ctl %b rdata %h addr %h state %0d expected 0", ctl, bus.dc_rdata, bus.mem_addr, dut.state);
                end
            end
            if (c == 7 || c == 8) begin
                checks++;
                if (bus.dc_rvalid !== 1'b0) begin errors++; $display("FAIL rst_late_return: got dc_rvalid 1 expected 0"); end
            end
        end
    endtask

`ifdef ICACHE_ABORT_EN
    task automatic test_abort();
        int dg = -1, icv = 0, reqs = 0, acc = 0;
        do_reset();
        auto_mem = 1'b0;
        bus.ic_addr = 32'h6000; bus.ic_req = 1'b1; bus.mem_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.ic_gnt) bus.ic_req = 1'b0;
            bus.mem_ready = (c != 2);
            bus.ic_abort  = (c == 2);
            if (c == 2) begin bus.dc_req = 1'b1; bus.dc_addr = 32'h7000; bus.dc_we = 1'b0; end
            if (bus.dc_gnt) begin dg = c; bus.dc_req = 1'b0; end
            man_rv = (c == 3 || c == 5);
            #1;
            if (bus.ic_rvalid || bus.ic_done) icv++;
            if (c >= 3 && c <= 6 && bus.mem_req) reqs++;
            if (c < 2 && bus.mem_req && bus.mem_ready) acc++;
            if (c == 4) begin
                checks++;
                if (dut.state !== 3'd4) begin errors++; $display("FAIL abort_drain: got state %0d expected 4", dut.state); end
            end
            if (c == 6) begin
                checks++;
                if (dut.state !== 3'd0) begin errors++; $display("FAIL abort_idle: got state %0d expected 0", dut.state); end
            end
        end
        checks++;
        if (acc != 2 || reqs != 0) begin errors++; $display("FAIL abort_issue: got acc %0d later reqs %0d expected 2 0", acc, reqs); end
        checks++;
        if (icv != 0) begin errors++; $display("FAIL abort_ic_outputs: got %0d ic beats/done expected 0", icv); end
        checks++;
        if (dg != 7) begin errors++; $display("FAIL abort_dc_gnt: got cycle %0d expected 7", dg); end
    endtask
`endif

    initial begin
        test_reset();
        test_ic_burst();
        test_tie();
        test_writeback();
        test_stall();
        test_rst_mid();
`ifdef ICACHE_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
